// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// master: stream source / IM side (drives bytes, observes the write port).
// slave:  the loader (accepts bytes, drives the IM write port).
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Accepts LEN_HI, LEN_LO, then LEN
// big-endian 32-bit words over a valid/ready byte stream, writes each word
// to IM at byte address index<<2, and holds the CPU in reset until the
// image is complete.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: a trailing XOR checksum
// byte over all data bytes is required after the last word (also for len==0).
module imem_loader #(
    parameter int unsigned IMEM_SIZE = 128,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        ERR
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [15:0]      len_q;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    logic             ready;
    logic             xfer;
    logic [15:0]      len_full;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_word;

    assign xfer      = bus.byte_valid && ready;
    assign len_full  = {len_q[15:8], bus.byte_data};
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_word = (cnt_inc == CNT_W'(len_q));

    assign bus.byte_ready = ready;
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = data_q;
    assign words_loaded   = cnt_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode and per-state outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        bus.wr_en  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_next = LEN_HI;
            end
            LEN_HI: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (xfer) state_next = LEN_LO;
            end
            LEN_LO: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (xfer) begin
                    if (len_full == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    else if (len_full > 16'(IMEM_SIZE))
                        state_next = ERR;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (xfer && byte_idx == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                bus.wr_en = 1'b1;
                if (last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = DONE;
`endif
                else
                    state_next = DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (xfer) state_next = (bus.byte_data == csum_q) ? DONE : ERR;
            end
`endif
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_next = LEN_HI;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = LEN_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // Length capture, word assembly, address/counter bookkeeping.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            len_q    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            case (state)
                LEN_HI: begin
                    if (xfer) len_q[15:8] <= bus.byte_data;
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= bus.byte_data;
                        byte_idx   <= '0;
                        word_idx   <= '0;
                        cnt_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                DATA: begin
                    if (xfer) begin
                        data_q   <= {data_q[23:0], bus.byte_data};
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q   <= csum_q ^ bus.byte_data;
`endif
                        // Address is latched with the final byte so it is stable for the whole WRITE cycle.
                        if (byte_idx == 2'd3) addr_q <= 32'(word_idx) << 2;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + CNT_W'(1);
                    cnt_q    <= cnt_inc;
                    byte_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time loader that sits directly upstream of the instruction memory in the single-clock MIPS.
- Accepts a byte stream (valid/ready), assembles big-endian 32-bit instruction words, and drives the IM write port (write enable, byte address, write data).
- Holds the CPU in reset until a complete program image has been written.

Parameters:
- IMEM_SIZE, 128, instruction memory depth in 32-bit words; upper limit on the load length.
- CNT_W, 16, width of the length field and of the word counter.

Ports:
- CLK  input  1  clock
- RST  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse that begins a load
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte_data this cycle
- wr_en  output  1  IM write enable
- wr_addr  output  32  IM byte address; always word-aligned (index<<2)
- wr_data  output  32  IM write data
- cpu_hold  output  1  keeps the CPU in reset; high in every state except DONE
- busy  output  1  a load is in progress
- done  output  1  image fully written
- err  output  1  load rejected
- words_loaded  output  CNT_W  number of words written in the current load

Behaviour:
- Reset (RST==0 at posedge):
  - state=IDLE.
  - cpu_hold=1; all other outputs 0, including wr_addr/wr_data.
  - Internal length, byte index and word index cleared.
- Byte transfer occurs only on a cycle where byte_valid && byte_ready. Data must not be consumed on any other cycle.
- Stream format: LEN[15:8], LEN[7:0], then LEN words, each 4 bytes MSB first.
- States:
  - IDLE: byte_ready=0. start -> LEN_HI.
  - LEN_HI: byte_ready=1, busy=1. On transfer, len[15:8]=byte -> LEN_LO.
  - LEN_LO: byte_ready=1. On transfer, len[7:0]=byte. Next state:
    - full len==0 -> DONE
    - len>IMEM_SIZE -> ERR
    - else -> DATA, with word index and words_loaded cleared.
  - DATA: byte_ready=1. Each transfer shifts the byte into the word register (wr_data <= {wr_data[23:0],byte}) and increments byte index 0..3. The transfer with index==3 goes -> WRITE.
  - WRITE (exactly 1 cycle):
    - byte_ready=0, wr_en=1.
    - wr_addr = word_index<<2; wr_data = the assembled word.
    - Next edge: word index and words_loaded increment; byte index returns to 0.
    - If the incremented count == len -> DONE, else -> DATA.
  - DONE: done=1, busy=0, cpu_hold=0. start -> LEN_HI, which clears done, raises cpu_hold and starts a reload.
  - ERR: err=1, busy=0, byte_ready=0, cpu_hold=1. err is sticky. start clears err -> LEN_HI.
- wr_en is 0 in every state except WRITE. wr_addr/wr_data hold their last value outside WRITE.
- Throughput: at most one word per 5 cycles (4 accepted bytes + 1 WRITE cycle).
- start is ignored while busy=1.
- byte_valid with no start pending (IDLE/DONE/ERR): not accepted, no effect.
- Stalls: byte_valid low mid-word leaves the byte index and partial word unchanged, with no timeout.
- Reset mid-load: aborts immediately. A partially assembled word is never written. Words already written remain in IM. cpu_hold returns to 1.
- len==IMEM_SIZE is legal. The final word goes to address (IMEM_SIZE-1)<<2, and there is no wrap-around.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last WRITE, go to state CSUM (byte_ready=1) and accept one extra byte.
  - Compare it with the XOR of all data bytes (running XOR cleared in LEN_LO).
  - Match -> DONE; mismatch -> ERR.
  - For len==0 the checksum byte is still expected and must be 0x00.
- When not defined: no CSUM state, no running XOR, and the final WRITE goes directly to DONE.

Test Plan:
- RST low 2 cycles, then high -> cpu_hold=1, done=0, err=0, wr_en=0, byte_ready=0; bytes offered in IDLE are not accepted.
- start, stream 00 02 | 20 08 00 05 | AC 08 00 04 -> two wr_en pulses: (0x0,0x20080005), then (0x4,0xAC080004); done=1, cpu_hold=0, words_loaded=2.
- start, len 00 81 (129 > 128) -> ERR, err=1, no wr_en. A second start with len 00 01 and word 00000000 -> done=1, err=0.
- Load of len=3 with byte_valid deasserted for 7 cycles between bytes 2 and 3 of word 1 -> word 1 still written as the correct big-endian value at 0x4; the 3 writes go to 0x0, 0x4, 0x8.
- RST asserted after 2 bytes of word 1 of a len=4 load -> no wr_en for word 1, only word 0 was written, state IDLE, cpu_hold=1.
- With IMEM_LOADER_CHECKSUM_EN: len 1, word 12 34 56 78, checksum 08 -> DONE. Same load with checksum 09 -> err=1, cpu_hold=1.
